// File: rtl/pll_reset_sequencer_pkg.sv
// pll_reset_sequencer_pkg: state encoding, status widths and counter sizing shared by the
// reset sequencer and the status/LED block.
package pll_reset_sequencer_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STRETCH   = 2'd2,
      RUN       = 2'd3
   } seq_state_e;

   localparam int RETRY_W = 4;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int ab;
      int cd;
      ab = (a > b) ? a : b;
      cd = (c > d) ? c : d;
      return (ab > cd) ? ab : cd;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// sync2: two-flop synchroniser for asynchronous single-bit inputs, clears to 0 on reset.
module sync2 (
   input  logic clock,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         q_o    <= 1'b0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds the PLL in reset, debounces its lock, then stretches the
// design reset before releasing it; resequences on lock loss or soft restart.
module pll_reset_sequencer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int RST_CYCLES     = 16,
   parameter int LOCK_CYCLES    = 1024,
   parameter int STRETCH_CYCLES = 256,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int CNT_W          = $clog2(max4(RST_CYCLES, LOCK_CYCLES, STRETCH_CYCLES, TIMEOUT_CYCLES)) + 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               pll_lock,
   input  logic               restart,
   output logic               pll_resetb,
   output logic               sys_reset,
   output logic               ready,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retries,
   output logic [1:0]         state
);

   localparam logic [CNT_W-1:0] RST_LD     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LD    = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

   logic               lock_s;
   seq_state_e         st_q, st_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   tmo_q, tmo_d;
   logic [RETRY_W-1:0] retries_q, retries_d;
   logic               lock_lost_q, lock_lost_d;
   logic               pll_resetb_q, sys_reset_q, ready_q;
   logic               accept;

   sync2 u_lock_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d_i     (pll_lock),
      .q_o     (lock_s)
   );

   assign accept = lock_s && (cnt_q == '0);

   always_comb begin
      st_d        = st_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      retries_d   = retries_q;
      lock_lost_d = lock_lost_q;
      case (st_q)
         PLL_RST: begin
            if (cnt_q == '0) begin
               st_d  = WAIT_LOCK;
               cnt_d = LOCK_LD;
               tmo_d = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WAIT_LOCK: begin
            tmo_d = tmo_q + 1'b1;
            if (!lock_s) begin
               cnt_d = LOCK_LD;
            end else if (accept) begin
               st_d  = STRETCH;
               cnt_d = STRETCH_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
            // acceptance on the final timeout cycle still counts as a lock
            if (tmo_q == TMO_LAST && !accept) begin
               st_d      = PLL_RST;
               cnt_d     = RST_LD;
               retries_d = (retries_q == '1) ? retries_q : retries_q + 1'b1;
            end
         end
         STRETCH: begin
            if (!lock_s) begin
               st_d  = PLL_RST;
               cnt_d = RST_LD;
            end else if (cnt_q == '0) begin
               st_d = RUN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RUN: begin
            if (!lock_s) begin
               st_d        = PLL_RST;
               cnt_d       = RST_LD;
               lock_lost_d = 1'b1;
            end
         end
      endcase
      if (restart) begin
         st_d  = PLL_RST;
         cnt_d = RST_LD;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         st_q         <= PLL_RST;
         cnt_q        <= RST_LD;
         tmo_q        <= '0;
         retries_q    <= '0;
         lock_lost_q  <= 1'b0;
         pll_resetb_q <= 1'b0;
         sys_reset_q  <= 1'b1;
         ready_q      <= 1'b0;
      end else begin
         st_q         <= st_d;
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
         retries_q    <= retries_d;
         lock_lost_q  <= lock_lost_d;
         pll_resetb_q <= (st_d != PLL_RST);
         sys_reset_q  <= (st_d != RUN);
         ready_q      <= (st_d == RUN);
      end
   end

   assign pll_resetb = pll_resetb_q;
   assign sys_reset  = sys_reset_q;
   assign ready      = ready_q;
   assign lock_lost  = lock_lost_q;
   assign retries    = retries_q;
   assign state      = st_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the board PLL and design reset on the 12 MHz reference clock. It holds the PLL in reset, waits for a debounced lock, and stretches the design reset after lock. On loss of lock or a soft restart request, it re-runs the sequence. It sits between the iCE40 PLL primitive wrapper (driving its RESETB, reading its LOCK) and the top-level reset distribution. Downstream logic re-synchronises `sys_reset` into the PLL output domain.

## Interface
Parameters:
- RST_CYCLES, 16: cycles `pll_resetb` is held low per attempt (≥1).
- LOCK_CYCLES, 1024: consecutive synced-lock-high cycles required to accept lock (≥1).
- STRETCH_CYCLES, 256: cycles `sys_reset` stays high after lock is accepted (≥1).
- TIMEOUT_CYCLES, 65536: maximum WAIT_LOCK cycles before retry; must exceed LOCK_CYCLES.
- CNT_W, $clog2(max of above)+1: shared down-counter width.

Ports:
- clock, in, 1: reference clock, the only clock.
- reset_n, in, 1: asynchronous, active-low reset.
- pll_lock, in, 1: PLL LOCK output, asynchronous to `clock`.
- restart, in, 1: synchronous single-cycle soft restart request.
- pll_resetb, out, 1: to PLL RESETB; 0 holds the PLL in reset.
- sys_reset, out, 1: active-high design reset.
- ready, out, 1: high only in RUN.
- lock_lost, out, 1: sticky; set on lock loss in RUN; cleared by `reset_n` only.
- retries, out, 4: saturating count of WAIT_LOCK timeouts; cleared by `reset_n` only.
- state, out, 2: current state encoding (debug).

## Operation
- `pll_lock` passes through a 2-flop synchroniser to `lock_s`; all decisions use `lock_s`.
- A single down-counter `cnt` serves every state. A second counter `tmo` is used only in WAIT_LOCK.
- States (encoding 0–3): PLL_RST, WAIT_LOCK, STRETCH, RUN.
- PLL_RST:
  - Outputs: `pll_resetb`=0, `sys_reset`=1.
  - `cnt` loads RST_CYCLES-1 on entry. When `cnt`==0, go to WAIT_LOCK.
- WAIT_LOCK:
  - Outputs: `pll_resetb`=1, `sys_reset`=1.
  - `cnt` reloads LOCK_CYCLES-1 whenever `lock_s`=0 and decrements while `lock_s`=1.
  - `cnt`==0 with `lock_s`=1: go to STRETCH.
  - `tmo` reaching TIMEOUT_CYCLES-1 without acceptance: increment `retries` (saturating at 15), go to PLL_RST.
  - If acceptance and timeout fall on the same cycle, acceptance wins.
- STRETCH:
  - Outputs: `pll_resetb`=1, `sys_reset`=1.
  - `cnt` loads STRETCH_CYCLES-1 on entry. At `cnt`==0, go to RUN.
  - `lock_s`=0 here returns to PLL_RST without setting `lock_lost`.
- RUN:
  - Outputs: `pll_resetb`=1, `sys_reset`=0, `ready`=1.
  - `lock_s`=0: set `lock_lost`, go to PLL_RST.
- `restart`=1 in any state sends the FSM to PLL_RST next cycle, reloading `cnt`. If it coincides with a lock loss in RUN, `lock_lost` is still set.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Timing
- Reset values: `pll_resetb`=0, `sys_reset`=1, `ready`=0, `lock_lost`=0, `retries`=0, `state`=PLL_RST, synchroniser=0, counters loaded for PLL_RST.
- Asserting `reset_n` mid-sequence forces these values immediately, with no clock required.
- PLL_RST lasts exactly RST_CYCLES cycles.
- Best case from `reset_n` release to `ready`=1, with `pll_lock` already high: RST_CYCLES + 2 (sync) + LOCK_CYCLES + STRETCH_CYCLES cycles, ±1.
- Lock drop in RUN: `sys_reset` rises 3 cycles after the `pll_lock` edge (2 sync + 1 register). `pll_resetb` falls on the same cycle.
- `restart` at cycle t: `sys_reset`=1 and `pll_resetb`=0 at t+1.
- A lock glitch shorter than LOCK_CYCLES during WAIT_LOCK restarts the debounce. It never advances the FSM.

## Structure
- Shared package: state encoding constants (PLL_RST=0, WAIT_LOCK=1, STRETCH=2, RUN=3) and the `retries` width, reused by the status/LED block.
- One sub-module, `sync2`: a 2-flop synchroniser, async active-low reset to 0, reused elsewhere for the button inputs.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_CYCLES=8, STRETCH_CYCLES=5, TIMEOUT_CYCLES=40.
- Clean start: `pll_lock` rises 10 cycles after `reset_n` release and stays high. Required: `pll_resetb` low for exactly 4 cycles, then `ready`=1 after 8 stable lock cycles plus 5 stretch cycles, `retries`=0, `lock_lost`=0.
- Glitchy lock: `pll_lock` high 6, low 1, high 20. Required: debounce restarts and STRETCH is entered only after 8 consecutive `lock_s` highs.
- Timeout: `pll_lock` held low. Required: `retries` increments every 4+40 cycles and saturates at 15; `sys_reset` stays 1 throughout.
- Lock loss in RUN: drop `pll_lock` for 1 cycle. Required: `sys_reset`=1 three cycles later, `lock_lost`=1 sticky, full resequence completes, `ready` returns to 1.
- Restart collision: `restart` pulse in STRETCH. Required: PLL_RST next cycle, `lock_lost` stays 0. A second `restart` in RUN, on the same cycle as lock loss, gives `lock_lost`=1.
- Async reset mid-WAIT_LOCK: pull `reset_n` low between clock edges. Required: all outputs reach reset values immediately and `retries` clears.
